// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef logic [1:0] arb_idx_t;

    // Turn a requester index into the matching one-hot grant vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input arb_idx_t idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: finds the first asserted request
// scanning upward from the requester just after 'last', wrapping 3 -> 0.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  arb_idx_t        last,
    output arb_idx_t        idx,
    output logic            any
);

    arb_idx_t cand;

    // Scan last+1 .. last+4 (mod 4); the final step lands on 'last' itself,
    // which is why the previous owner ends up with the lowest priority.
    always_comb begin
        idx  = last;
        any  = 1'b0;
        cand = last;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + arb_idx_t'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one downstream resource among four requesters.
// Grants are held until the resource reports done or the owner withdraws.
// Optional watchdog (macro ARB_TIMEOUT_EN) force-releases a grant held for
// MAX_HOLD cycles and pulses 'timeout' for one cycle.
module bus_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output arb_idx_t        sel,
    output logic            gnt_valid,
    output logic            timeout
);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    arb_idx_t        sel_q, sel_d;
    arb_idx_t        last_q, last_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;

    arb_idx_t        pick_idx;
    logic            pick_any;
    logic            grant_new;
    logic            release_now;
    logic            expire;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Watchdog fires only when it is the sole reason to release: a done or a
    // withdrawal in the same cycle takes the normal path without a pulse.
    assign expire = (state_q == GRANT)
                 && (hold_cnt_q == CNT_W'(MAX_HOLD - 1))
                 && !done
                 && req[sel_q];

    // Hold counter restarts on every new grant and counts grant cycles.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (grant_new) begin
            hold_cnt_d = '0;
        end else if (state_q == GRANT) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_max_hold;

    assign expire          = 1'b0;
    assign unused_max_hold = (MAX_HOLD == 0);
`endif

    // Next-state logic: pick a new owner from IDLE, or on any release in
    // GRANT hand over directly to the next requester without an idle bubble.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        grant_new   = 1'b0;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                release_now = done || !req[sel_q] || expire;
                if (release_now) begin
                    if (pick_any) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
        endcase
        if (grant_new) begin
            state_d = GRANT;
            gnt_d   = idx_to_onehot(pick_idx);
            sel_d   = pick_idx;
            last_d  = pick_idx;
        end
        gnt_valid_d = |gnt_d;
        timeout_d   = expire;
    end

    // State and output registers; last starts at 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            last_q      <= 2'd3;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: stimulus pushes expected outputs into a
// queue, a monitor pops one entry per clock and compares.
module tb_bus_arbiter4;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD = 4;
`else
    localparam int unsigned HOLD = 16;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       tmo;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    logic       timeout;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    bus_arbiter4 #(
        .MAX_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare all outputs against one expected set.
    task automatic checkOutput(input string nm, input logic [3:0] eg, input logic [1:0] es,
                               input logic ev, input logic et);
        checks++;
        if (gnt !== eg || sel !== es || gnt_valid !== ev || timeout !== et) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b sel=%0d valid=%b timeout=%b, expected gnt=%b sel=%0d valid=%b timeout=%b",
                     nm, gnt, sel, gnt_valid, timeout, eg, es, ev, et);
        end
    endtask

    // Queue what the outputs must look like after the next rising edge.
    task automatic pushExpected(input logic [3:0] eg, input logic [1:0] es, input logic et,
                                input string nm);
        exp_t e;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = |eg;
        e.tmo   = et;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and record the expectation.
    task automatic applyStimulus(input logic [3:0] r, input logic d, input logic [3:0] eg,
                                 input logic [1:0] es, input logic et, input string nm);
        @(negedge clk);
        req  = r;
        done = d;
        pushExpected(eg, es, et, nm);
    endtask

    // Monitor: one scoreboard entry per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name, e.gnt, e.sel, e.valid, e.tmo);
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL time_limit: got simulation still running, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;

        // Reset with every requester asking: nothing may be granted.
        #2;
        checkOutput("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release reset: requester 0 has top priority.
        @(negedge clk);
        reset_n = 1'b1;
        pushExpected(4'b0001, 2'd0, 1'b0, "reset_release");

        // Round robin with done every third cycle.
        applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rr_hold0a");
        applyStimulus(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rr_hold0b");
        applyStimulus(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0, "rr_to1");
        applyStimulus(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, "rr_hold1a");
        applyStimulus(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, "rr_hold1b");
        applyStimulus(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0, "rr_to2");
        applyStimulus(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "rr_hold2a");
        applyStimulus(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "rr_hold2b");
        applyStimulus(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0, "rr_to3");
        applyStimulus(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "rr_hold3a");
        applyStimulus(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "rr_hold3b");
        applyStimulus(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, "rr_wrap0");

        // Back-to-back handover with no idle bubble.
        applyStimulus(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0, "b2b_to1");

        // Owner 1 withdraws while 2 asks: direct handover to 2.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "withdraw_to2");
        applyStimulus(4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0, "hold_ignore_others");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, "withdraw_idle");
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, "done_in_idle");

        // Grant 3, then assert reset in the middle of the cycle.
        applyStimulus(4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0, "grant3");
        applyStimulus(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "hold3");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        req     = 4'b0000;
        pushExpected(4'b0000, 2'd0, 1'b0, "post_reset_idle");

        // Done and withdrawal together act as a single release.
        applyStimulus(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "grant2_after_reset");
        applyStimulus(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "done_and_withdraw");
        applyStimulus(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "owner_sole_rerequest");
        applyStimulus(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b0, "owner_lowest_prio");
        applyStimulus(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, "done_to_idle");

`ifdef ARB_TIMEOUT_EN
        // Watchdog: four grant cycles, then a forced release with a pulse.
        applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tmo_grant");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tmo_hold");
        end
        applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "tmo_expire");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "tmo_hold_again");
        end
        applyStimulus(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "tmo_done_wins");
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "tmo_idle");
`else
        // No watchdog: a grant is held well beyond MAX_HOLD cycles.
        applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "long_grant");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "long_hold");
        end
        applyStimulus(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "long_idle");
`endif

        // Let the monitor drain the scoreboard, with a cycle budget.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d entries pending, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
